// File: rtl/i2c_bus_monitor.sv
// Passive multi-channel I2C bus monitor with a WISHBONE register interface.
// Define I2C_MON_TIMEOUT_EN to build the SCL-low timeout counters and the TOLIM registers.

module i2c_bus_monitor #(
  parameter int          NCH    = 2,
  parameter int          FILT   = 2,
  parameter logic [15:0] TO_RST = 16'hFFFF
) (
  input  logic           wb_clk_i,
  input  logic           arst_i,
  input  logic           wb_rst_i,
  input  logic [2:0]     wb_adr_i,
  input  logic [7:0]     wb_dat_i,
  output logic [7:0]     wb_dat_o,
  input  logic           wb_we_i,
  input  logic           wb_stb_i,
  input  logic           wb_cyc_i,
  output logic           wb_ack_o,
  output logic           wb_inta_o,
  input  logic [NCH-1:0] scl_i,
  input  logic [NCH-1:0] sda_i
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ACK} state_t;

  logic           ctrl_en, ctrl_ien;
  logic [CW-1:0]  chsel;
  logic [15:0]    tolim;
  logic           acc, wr, rd;
  logic [7:0]     rd_mux;
  logic [7:0]     stat_a [NCH];
  logic [7:0]     rxb_a  [NCH];
  logic [3:0]     err_a  [NCH];
  logic [7:0]     cnt_a  [NCH];
  logic [NCH-1:0] err_or;

  assign acc = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr  = acc & wb_we_i;
  assign rd  = acc & ~wb_we_i;

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = 8'h00;
    case (wb_adr_i)
      3'd0: rd_mux = {6'b000000, ctrl_ien, ctrl_en};
      3'd1: rd_mux = 8'(chsel);
      3'd2: rd_mux = stat_a[chsel];
      3'd3: rd_mux = rxb_a[chsel];
      3'd4: rd_mux = {4'b0000, err_a[chsel]};
      3'd5: rd_mux = cnt_a[chsel];
      3'd6: rd_mux = tolim[7:0];
      3'd7: rd_mux = tolim[15:8];
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wb_ack_o <= 1'b0; wb_dat_o <= 8'h00; wb_inta_o <= 1'b0;
      ctrl_en  <= 1'b0; ctrl_ien <= 1'b0; chsel     <= '0;
    end else if (wb_rst_i) begin
      wb_ack_o <= 1'b0; wb_dat_o <= 8'h00; wb_inta_o <= 1'b0;
      ctrl_en  <= 1'b0; ctrl_ien <= 1'b0; chsel     <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      wb_ack_o  <= acc;
      wb_inta_o <= ctrl_ien & (|err_or);
      if (rd) wb_dat_o <= rd_mux;
      if (wr && wb_adr_i == 3'd0) begin
        ctrl_en  <= wb_dat_i[0];
        ctrl_ien <= wb_dat_i[1];
      end
      if (wr && wb_adr_i == 3'd1)
        chsel <= (wb_dat_i >= 8'(NCH)) ? CW'(NCH - 1) : wb_dat_i[CW-1:0];
    end
  end

`ifdef I2C_MON_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i)                        tolim        <= TO_RST;
    else if (wb_rst_i)                  tolim        <= TO_RST;
    else if (wr && wb_adr_i == 3'd6)    tolim[7:0]   <= wb_dat_i;
    else if (wr && wb_adr_i == 3'd7)    tolim[15:8]  <= wb_dat_i;
  end
`else
  assign tolim = 16'h0000;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]      ln_s1, ln_s2, ln_f, ln_d;  // bit 1 = scl, bit 0 = sda
    logic [1:0][2:0] fcnt;
    state_t          state;
    logic [3:0]      bitcnt, pos, err, err_set;
    logic [7:0]      shreg, rxb, cnt;
    logic            hi_bit, nack, bvalid;
    logic            sel, rd_rxb, wr_err, wr_cnt;
    logic            start_ev, stop_ev, scl_rise, timeout, complete;

    assign sel    = (chsel == CW'(i));
    assign rd_rxb = rd & sel & (wb_adr_i == 3'd3);
    assign wr_err = wr & sel & (wb_adr_i == 3'd4);
    assign wr_cnt = wr & sel & (wb_adr_i == 3'd5);

    // A line change is accepted only after FILT consecutive samples disagree with ln_f.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
        ln_s1 <= 2'b11; ln_s2 <= 2'b11; ln_f <= 2'b11; ln_d <= 2'b11; fcnt <= '0;
      end else if (wb_rst_i) begin
        ln_s1 <= 2'b11; ln_s2 <= 2'b11; ln_f <= 2'b11; ln_d <= 2'b11; fcnt <= '0;
      end else begin
        ln_s1 <= {scl_i[i], sda_i[i]};
        ln_s2 <= ln_s1;
        ln_d  <= ln_f;
        for (int k = 0; k < 2; k++) begin
          if (ln_s2[k] == ln_f[k]) begin
            fcnt[k] <= 3'd0;
          end else if (fcnt[k] == 3'(FILT - 1)) begin
            ln_f[k] <= ln_s2[k];
            fcnt[k] <= 3'd0;
          end else begin
            fcnt[k] <= fcnt[k] + 3'd1;
          end
        end
      end
    end

    assign start_ev = ln_f[1] & ln_d[1] &  ln_d[0] & ~ln_f[0];
    assign stop_ev  = ln_f[1] & ln_d[1] & ~ln_d[0] &  ln_f[0];
    assign scl_rise = ln_f[1] & ~ln_d[1];
    // The SCL rise that opens a START/STOP was already counted as a bit; judge position without it.
    assign pos      = bitcnt - {3'b000, hi_bit};

`ifdef I2C_MON_TIMEOUT_EN
    logic [15:0] tocnt;
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i)                         tocnt <= 16'd0;
      else if (wb_rst_i)                   tocnt <= 16'd0;
      else if (state == S_IDLE || ln_f[1]) tocnt <= 16'd0;
      else if (tocnt != 16'hFFFF)          tocnt <= tocnt + 16'd1;
    end
    assign timeout = (tolim != 16'd0) && (state != S_IDLE) && !ln_f[1] && (tocnt >= tolim);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
      err_set  = 4'b0000;
      complete = 1'b0;
      if (ctrl_en && state != S_IDLE) begin
        if (timeout)       err_set[2] = 1'b1;
        else if (start_ev) err_set[0] = (state == S_ACK) || (pos != 4'd0);
        else if (stop_ev)  err_set[1] = (state == S_ACK) || (pos != 4'd0);
        else if (scl_rise && state == S_ACK) complete = 1'b1;
      end
      err_set[3] = complete & bvalid & ~rd_rxb;
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
        state <= S_IDLE; bitcnt <= 4'd0; hi_bit <= 1'b0; shreg <= 8'h00; rxb <= 8'h00;
        nack  <= 1'b0;   bvalid <= 1'b0; err    <= 4'h0; cnt   <= 8'h00;
      end else if (wb_rst_i) begin
        state <= S_IDLE; bitcnt <= 4'd0; hi_bit <= 1'b0; shreg <= 8'h00; rxb <= 8'h00;
        nack  <= 1'b0;   bvalid <= 1'b0; err    <= 4'h0; cnt   <= 8'h00;
      end else begin
        if (!ctrl_en || (state != S_IDLE && (timeout || stop_ev))) begin
          state <= S_IDLE; bitcnt <= 4'd0; hi_bit <= 1'b0;
        end else if (start_ev) begin
          state <= S_DATA; bitcnt <= 4'd0; hi_bit <= 1'b0;
        end else if (scl_rise && state == S_DATA) begin
          shreg  <= {shreg[6:0], ln_f[0]};
          bitcnt <= bitcnt + 4'd1;
          hi_bit <= 1'b1;
          if (bitcnt == 4'd7) state <= S_ACK;
        end else if (scl_rise && state == S_ACK) begin
          nack  <= ln_f[0]; rxb <= shreg;
          state <= S_DATA;  bitcnt <= 4'd0; hi_bit <= 1'b0;
        end else if (!ln_f[1]) begin
          hi_bit <= 1'b0;
        end
        err    <= (err & ~(wr_err ? wb_dat_i[3:0] : 4'h0)) | err_set;
        bvalid <= complete | (bvalid & ~rd_rxb);
        if (wr_cnt)        cnt <= 8'h00;
        else if (complete) cnt <= cnt + 8'd1;
      end
    end

    assign stat_a[i] = {bvalid, bitcnt, nack, state == S_ACK, state != S_IDLE};
    assign rxb_a[i]  = rxb;
    assign err_a[i]  = err;
    assign cnt_a[i]  = cnt;
    assign err_or[i] = |err;
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed self-checking bench for i2c_bus_monitor (NCH=2, FILT=2); follows I2C_MON_TIMEOUT_EN.
`timescale 1ns/1ps

module tb_i2c_bus_monitor;
  localparam int NCH = 2;
  localparam int H   = 8;  // clocks per I2C line phase
`ifdef I2C_MON_TIMEOUT_EN
  localparam logic [7:0] TO_RD = 8'hFF;
`else
  localparam logic [7:0] TO_RD = 8'h00;
`endif

  logic           wb_clk_i = 1'b0;
  logic           arst_i, wb_rst_i;
  logic [2:0]     wb_adr_i;
  logic [7:0]     wb_dat_i, wb_dat_o;
  logic           wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_inta_o;
  logic [NCH-1:0] scl_r, sda_r;
  int             checks = 0;
  int             failures = 0;

  i2c_bus_monitor #(.NCH(NCH), .FILT(2), .TO_RST(16'hFFFF)) dut (
    .wb_clk_i (wb_clk_i), .arst_i  (arst_i),  .wb_rst_i (wb_rst_i),
    .wb_adr_i (wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o (wb_dat_o),
    .wb_we_i  (wb_we_i),  .wb_stb_i(wb_stb_i), .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o), .wb_inta_o(wb_inta_o),
    .scl_i    (scl_r),    .sda_i   (sda_r)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [7:0] v,
                         output logic [7:0] d);
    int n;
    @(negedge wb_clk_i);
    wb_adr_i = a; wb_dat_i = v; wb_we_i = we; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin @(posedge wb_clk_i); #1; n++; end while (!wb_ack_o && n < 4);
    d = wb_dat_o;
    checks++;
    if (wb_ack_o !== 1'b1) begin
      failures++; $display("FAIL wb_ack_timeout adr=%0d got=%b exp=1", a, wb_ack_o);
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] v);
    logic [7:0] d;
    wb_xfer(1'b1, a, v, d);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] d);
    wb_xfer(1'b0, a, 8'h00, d);
  endtask

  task automatic set_ln(input int ch, input logic scl, input logic sda);
    scl_r[ch] = scl; sda_r[ch] = sda;
    wait_clk(H);
  endtask

  task automatic i2c_start(input int ch);
    set_ln(ch, 1, 1); set_ln(ch, 1, 0); set_ln(ch, 0, 0);
  endtask

  task automatic i2c_restart(input int ch);
    set_ln(ch, 0, 1); set_ln(ch, 1, 1); set_ln(ch, 1, 0); set_ln(ch, 0, 0);
  endtask

  task automatic i2c_stop(input int ch);
    set_ln(ch, 0, 0); set_ln(ch, 1, 0); set_ln(ch, 1, 1);
    wait_clk(4);
  endtask

  task automatic i2c_bit(input int ch, input logic b);
    set_ln(ch, 0, b); set_ln(ch, 1, b); set_ln(ch, 0, b);
  endtask

  task automatic i2c_byte(input int ch, input logic [7:0] b, input logic ack);
    for (int k = 7; k >= 0; k--) i2c_bit(ch, b[k]);
    i2c_bit(ch, ack);
  endtask

  task automatic test_reset;
    logic [7:0] d, exp;
    arst_i = 1'b0; wb_rst_i = 1'b0; wb_adr_i = 3'd0; wb_dat_i = 8'h00;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; scl_r = '1; sda_r = '1;
    wait_clk(3);
    @(negedge wb_clk_i); arst_i = 1'b1;
    wait_clk(2);
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin failures++; $display("FAIL rst_dat got=%02h exp=00", wb_dat_o); end
    checks++; if (wb_inta_o !== 1'b0) begin failures++; $display("FAIL rst_inta got=%b exp=0", wb_inta_o); end
    for (int a = 0; a < 8; a++) begin
      exp = (a >= 6) ? TO_RD : 8'h00;
      wb_rd(3'(a), d);
      checks++; if (d !== exp) begin failures++; $display("FAIL rst_reg%0d got=%02h exp=%02h", a, d, exp); end
      wait_clk(1);
      checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL ack_pulse%0d got=%b exp=0", a, wb_ack_o); end
    end
  endtask

  task automatic test_byte;
    logic [7:0] d;
    wb_wr(3'd0, 8'h01);
    i2c_start(0); i2c_byte(0, 8'hA5, 1'b0); i2c_stop(0);
    wb_rd(3'd2, d); checks++; if (d !== 8'h80) begin failures++; $display("FAIL byte_stat got=%02h exp=80", d); end
    wb_rd(3'd5, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL byte_cnt got=%02h exp=01", d); end
    wb_rd(3'd4, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL byte_err got=%02h exp=00", d); end
    wb_rd(3'd3, d); checks++; if (d !== 8'hA5) begin failures++; $display("FAIL byte_rxb got=%02h exp=a5", d); end
    wb_rd(3'd2, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL byte_stat_clr got=%02h exp=00", d); end
  endtask

  task automatic test_stop_err;
    logic [7:0] d;
    wb_wr(3'd0, 8'h03);
    i2c_start(0); i2c_bit(0, 1); i2c_bit(0, 0); i2c_bit(0, 1); i2c_bit(0, 1);
    checks++; if (wb_inta_o !== 1'b0) begin failures++; $display("FAIL stop_inta_pre got=%b exp=0", wb_inta_o); end
    i2c_stop(0);
    checks++; if (wb_inta_o !== 1'b1) begin failures++; $display("FAIL stop_inta got=%b exp=1", wb_inta_o); end
    wb_rd(3'd4, d); checks++; if (d !== 8'h02) begin failures++; $display("FAIL stop_err got=%02h exp=02", d); end
    wb_rd(3'd2, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL stop_stat got=%02h exp=00", d); end
    wb_wr(3'd4, 8'h02);
    wait_clk(1);
    checks++; if (wb_inta_o !== 1'b0) begin failures++; $display("FAIL stop_inta_clr got=%b exp=0", wb_inta_o); end
    wb_rd(3'd4, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL stop_err_clr got=%02h exp=00", d); end
  endtask

  task automatic test_misplaced_start;
    logic [7:0] d;
    i2c_start(0); i2c_bit(0, 1); i2c_bit(0, 1); i2c_bit(0, 0);
    i2c_restart(0); i2c_stop(0);
    wb_rd(3'd4, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL mstart_err got=%02h exp=01", d); end
    checks++; if (wb_inta_o !== 1'b1) begin failures++; $display("FAIL mstart_inta got=%b exp=1", wb_inta_o); end
    wb_wr(3'd4, 8'h01);
    wb_rd(3'd4, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL mstart_clr got=%02h exp=00", d); end
  endtask

  task automatic test_timeout;
    logic [7:0] d;
`ifdef I2C_MON_TIMEOUT_EN
    wb_wr(3'd6, 8'd100); wb_wr(3'd7, 8'd0);
    i2c_start(0); wait_clk(120);
    wb_rd(3'd4, d); checks++; if (d !== 8'h04) begin failures++; $display("FAIL to_err got=%02h exp=04", d); end
    wb_rd(3'd2, d); checks++; if (d[0] !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", d[0]); end
    set_ln(0, 1, 0); set_ln(0, 1, 1);
    wb_wr(3'd4, 8'h04);
    wb_wr(3'd6, 8'd0);
    i2c_start(0); wait_clk(120);
    wb_rd(3'd4, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL to0_err got=%02h exp=00", d); end
    wb_rd(3'd2, d); checks++; if (d[0] !== 1'b1) begin failures++; $display("FAIL to0_busy got=%b exp=1", d[0]); end
    i2c_stop(0);
    wb_rd(3'd4, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL to0_stop got=%02h exp=00", d); end
`else
    wb_wr(3'd6, 8'h5A); wb_wr(3'd7, 8'hC3);
    wb_rd(3'd6, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL tolim_lo got=%02h exp=00", d); end
    wb_rd(3'd7, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL tolim_hi got=%02h exp=00", d); end
`endif
  endtask

  task automatic test_sync_reset;
    logic [7:0] d;
    @(negedge wb_clk_i); wb_rst_i = 1'b1;
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    wb_rd(3'd0, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL srst_ctrl got=%02h exp=00", d); end
    wb_rd(3'd5, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL srst_cnt got=%02h exp=00", d); end
    wb_rd(3'd6, d); checks++; if (d !== TO_RD) begin failures++; $display("FAIL srst_tolim got=%02h exp=%02h", d, TO_RD); end
  endtask

  task automatic test_channel;
    logic [7:0] d;
    wb_wr(3'd0, 8'h01); wb_wr(3'd1, 8'h01);
    i2c_start(1); i2c_byte(1, 8'h3C, 1'b1); i2c_stop(1);
    wb_rd(3'd2, d); checks++; if (d !== 8'h84) begin failures++; $display("FAIL ch1_stat got=%02h exp=84", d); end
    wb_rd(3'd3, d); checks++; if (d !== 8'h3C) begin failures++; $display("FAIL ch1_rxb got=%02h exp=3c", d); end
    wb_rd(3'd5, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL ch1_cnt got=%02h exp=01", d); end
    wb_wr(3'd1, 8'h00);
    wb_rd(3'd3, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL ch0_rxb got=%02h exp=00", d); end
    wb_rd(3'd5, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL ch0_cnt got=%02h exp=00", d); end
    wb_wr(3'd1, 8'h07);
    wb_rd(3'd1, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL chsel_clamp got=%02h exp=01", d); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    wb_wr(3'd1, 8'h00);
    i2c_start(0); i2c_byte(0, 8'h11, 1'b0); i2c_byte(0, 8'h22, 1'b0); i2c_stop(0);
    wb_rd(3'd5, d); checks++; if (d !== 8'h02) begin failures++; $display("FAIL ovr_cnt got=%02h exp=02", d); end
    wb_rd(3'd4, d); checks++; if (d !== 8'h08) begin failures++; $display("FAIL ovr_err got=%02h exp=08", d); end
    wb_rd(3'd3, d); checks++; if (d !== 8'h22) begin failures++; $display("FAIL ovr_rxb got=%02h exp=22", d); end
    wb_wr(3'd5, 8'h9C);
    wb_rd(3'd5, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL cnt_clr got=%02h exp=00", d); end
    wb_wr(3'd1, 8'h01);
    wb_rd(3'd5, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL ch1_cnt_kept got=%02h exp=01", d); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_stop_err();
    test_misplaced_start();
    test_timeout();
    test_sync_reset();
    test_channel();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Synthesizable, parametrised multi-channel I2C bus monitor. It passively observes NCH I2C buses, decodes START/STOP, bit and byte boundaries and ACK/NACK, and records captured bytes, byte counts and sticky protocol errors. A WISHBONE slave exposes this state and drives an interrupt. It sits beside the I2C master core as its in-silicon protocol checker.

## Interface
- NCH, 2: number of monitored buses, 1..8.
- FILT, 2: glitch-filter depth in clocks, 1..7. A line change is accepted only after FILT consecutive equal samples.
- TO_RST, 16'hFFFF: reset value of TOLIM.
- wb_clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-low.
- wb_rst_i  in  1  synchronous reset, active-high. Same effect as arst_i.
- wb_adr_i  in  3  register address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, registered.
- wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  WISHBONE request.
- wb_ack_o  out  1  transfer acknowledge.
- wb_inta_o  out  1  interrupt, registered.
- scl_i, sda_i  in  NCH each  raw bus line samples, one bit per channel.

## Operation
**Register map**
- Registers marked * refer to the channel selected by CHSEL.
- 0 CTRL (RW, reset 0x00):
  - [0] EN: monitor enable.
  - [1] IEN: interrupt enable.
  - [7:2] read as 0.
- 1 CHSEL (RW, reset 0): channel index. A write of a value ≥ NCH stores NCH-1.
- 2 STAT* (RO):
  - [0] busy.
  - [1] in ACK bit.
  - [2] last ACK, 1 = NACK.
  - [6:3] bit count, 0..8.
  - [7] byte valid.
- 3 RXB* (RO): last captured byte. A read clears STAT[7].
- 4 ERR* (W1C, sticky):
  - [0] misplaced START.
  - [1] misplaced STOP.
  - [2] SCL-low timeout.
  - [3] overrun.
- 5 CNT* (RW): bytes completed, 8-bit, wraps 255→0. Any write clears it to 0.
- 6/7 TOLIM lo/hi (RW, shared by all channels): timeout limit in clocks. 0 disables the timeout.

**Per-channel pipeline**
- Input path: 2-FF synchronizer, then FILT-deep filter. This produces filtered scl_f and sda_f.
- START: sda_f falls while scl_f is high.
- STOP: sda_f rises while scl_f is high.

**Per-channel FSM** (states IDLE, DATA, ACK):
- IDLE→DATA on START. Bit count is set to 0.
- DATA: each scl_f rising edge shifts sda_f into the shift register, MSB first, and increments bit count. After the 8th bit the FSM moves to ACK.
- ACK: the next scl_f rising edge samples ACK into STAT[2], then:
  - RXB ← shift register.
  - STAT[7] ← 1. If STAT[7] was already 1, ERR[3] ← 1.
  - CNT increments.
  - FSM → DATA with bit count 0.
- START in DATA with bit count 0 (repeated START): legal, stays in DATA.
- START with bit count 1..8, or START in ACK: ERR[0] ← 1; bit count restarts at 0.
- STOP with bit count 0: legal, → IDLE.
- STOP in any other position: ERR[1] ← 1, → IDLE.
- SCL-low timeout: while not IDLE, a counter runs while scl_f is low and clears while scl_f is high. When it reaches TOLIM (TOLIM ≠ 0): ERR[2] ← 1, → IDLE.

**Disable and interrupt**
- EN=0: all FSMs are held in IDLE and no error is set. Synchronizers keep running, and registers keep their values.
- wb_inta_o = IEN & OR over all channels of (|ERR).

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0x00, wb_inta_o=0. All STAT/ERR/CNT/RXB = 0. CTRL=0, CHSEL=0, TOLIM=TO_RST. FSMs in IDLE, filters preset to 1.
- Pad to filtered line latency: 2+FILT clocks. Filtered event to STAT/ERR/RXB update: 1 clock.
- WISHBONE:
  - wb_ack_o = stb & cyc & !wb_ack_o, registered. Ack comes 1 clock after the request and is a single-cycle pulse; there is no back-to-back ack.
  - Writes take effect on the ack edge.
  - Read data is valid while wb_ack_o is high.
- wb_inta_o follows an ERR or IEN change by 1 clock.
- Simultaneous events:
  - Byte completion and RXB read in the same clock: STAT[7] stays 1, no overrun.
  - ERR W1C and a new error on the same bit: set wins.
  - CNT write and byte completion: write wins, CNT=0.
  - START and timeout in the same clock: timeout wins, → IDLE.
- arst_i assertion mid-frame forces reset values immediately. After release, the FSM waits for a new START.

## Configuration
- I2C_MON_TIMEOUT_EN defined: timeout counters and the TOLIM registers are built.
- I2C_MON_TIMEOUT_EN undefined:
  - No timeout counters are built.
  - Addresses 6/7 read 0x00 and ignore writes.
  - ERR[2] is constant 0.

## Test plan
- Reset: release arst_i, read all addresses. Expect 0 everywhere except TOLIM = 0xFF/0xFF. wb_ack_o is a 1-clock pulse per access.
- Ch0, EN=1: START, 0xA5 MSB first, ACK=0, STOP. Expect RXB=0xA5, STAT=0x80, CNT=1, ERR=0. Reading RXB then gives STAT[7]=0.
- Ch0, IEN=1: START, 4 bits, STOP. Expect ERR=0x02 and wb_inta_o=1 one clock after the update. Writing 0x02 to ERR clears it, and wb_inta_o falls.
- TOLIM=100 (macro on): after START, hold SCL low 101 clocks. Expect ERR[2]=1 and STAT[0]=0. Repeat with TOLIM=0: no error.
- Ch1 traffic 0x3C, CHSEL=1: RXB=0x3C, CNT=1. CHSEL=0: RXB=0, CNT=0. A CHSEL write of 7 with NCH=2 reads back 1.
- Overrun: two bytes 0x11, 0x22 with no RXB read. Expect ERR[3]=1, RXB=0x22, CNT=2.
